// File: rtl/vga_pkg.sv
// Shared constants and types for the hex debug overlay: timing, cell geometry,
// field layout of the 160-bit RAM row word, and glyph coding.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 1280;
  localparam int unsigned V_ACTIVE = 1024;
  localparam int unsigned V_TOTAL  = 1066;
  localparam int unsigned NUM_ROWS = 46;
  localparam int unsigned NUM_REGS = 32;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;

  localparam int unsigned INSTR_COL  = 0;
  localparam int unsigned REG_COL    = 18;
  localparam int unsigned DATA_COL   = 28;
  localparam int unsigned INSTR_NIBS = 16;
  localparam int unsigned REG_NIBS   = 8;
  localparam int unsigned DATA_NIBS  = 16;

  typedef logic [11:0] rgb12_t;
  localparam rgb12_t FG_COLOUR = 12'hFFF;
  localparam rgb12_t BG_COLOUR = 12'h000;

  typedef logic [4:0] glyph_t;
  localparam glyph_t GLYPH_BLANK = 5'd16;

  // Nibble idx counts from the MS end of the row word (0 = word[159:156]).
  function automatic logic [3:0] nibble_at(input logic [159:0] word, input logic [5:0] idx);
    logic [7:0] base;
    base = 8'(6'd39 - idx) << 2;
    return word[base +: 4];
  endfunction

endpackage

// File: rtl/hex_font_rom.sv
// 17-glyph hex font (0-9, A-F, blank), 8x16 cells, one registered read per clk.
// Each glyph is a 5x7 pattern drawn two lines tall on lines 1..14.
module hex_font_rom
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  glyph_t     glyph,
  input  logic [3:0] glyph_line,
  output logic [7:0] bitmap
);

  logic [7:0]  bitmap_q, bitmap_d;
  logic [34:0] pattern;
  logic [2:0]  pat_row;
  logic [5:0]  base;

  function automatic logic [34:0] glyph_pattern(input glyph_t g);
    case (g)
      5'd0:    return {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      5'd1:    return {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      5'd2:    return {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      5'd3:    return {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      5'd4:    return {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      5'd5:    return {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      5'd6:    return {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      5'd7:    return {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      5'd8:    return {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      5'd9:    return {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      5'd10:   return {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      5'd11:   return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      5'd12:   return {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      5'd13:   return {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      5'd14:   return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      5'd15:   return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    pattern  = glyph_pattern(glyph);
    pat_row  = '0;
    base     = '0;
    bitmap_d = '0;
    if (glyph_line != 4'd0 && glyph_line != 4'd15) begin
      pat_row  = 3'((glyph_line - 4'd1) >> 1);
      base     = 6'(3'd6 - pat_row) * 6'd5;
      bitmap_d = {1'b0, pattern[base +: 5], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bitmap_q <= '0;
    else     bitmap_q <= bitmap_d;
  end

  assign bitmap = bitmap_q;

endmodule

// File: rtl/vga_hex_renderer.sv
// Renders the VGA debug RAM as an 8x16-cell hex overlay: one row fetch per
// scan line, 3-stage pixel pipe (cell decode, font ROM, colour select).
module vga_hex_renderer
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   pixel_x,
  input  logic [10:0]   pixel_y,
  input  logic          video_on_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [31:0]   read_address,
  input  logic [159:0]  ram_out,
  output logic [11:0]   vga_rgb,
  output logic          hsync,
  output logic          vsync
);

  logic [31:0]  read_address_q, read_address_d;
  logic [159:0] row_word_q, row_word_d;
  logic [6:0]   row_idx_q, row_idx_d;
  glyph_t       code_q, code_d;
  logic [3:0]   glyph_line_q, glyph_line_d;
  logic [2:0]   bit1_q, bit1_d, bit2_q, bit2_d;
  logic [1:0]   von_pipe_q, von_pipe_d;
  logic [2:0]   hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  rgb12_t       rgb_q, rgb_d;

  logic [10:0]  ny;
  logic [7:0]   col;
  logic [7:0]   font_bits;

  always_comb begin
    ny = (pixel_y == 11'(V_TOTAL - 1)) ? '0 : pixel_y + 11'd1;

    read_address_d = read_address_q;
    row_word_d     = row_word_q;
    row_idx_d      = row_idx_q;
    if (pixel_x == 11'(H_ACTIVE)) read_address_d = {25'd0, ny[10:4]};
    if (pixel_x == 11'(H_ACTIVE + 1)) begin
      row_word_d = ram_out;
      row_idx_d  = ny[10:4];
    end

    // Field columns map onto one running nibble index across the 160-bit word.
    col    = pixel_x[10:3];
    code_d = GLYPH_BLANK;
    if (row_idx_q < 7'(NUM_ROWS)) begin
      if (col < 8'(INSTR_COL + INSTR_NIBS))
        code_d = {1'b0, nibble_at(row_word_q, col[5:0])};
      else if (col >= 8'(REG_COL) && col < 8'(REG_COL + REG_NIBS) && row_idx_q < 7'(NUM_REGS))
        code_d = {1'b0, nibble_at(row_word_q, 6'(col - 8'(REG_COL - INSTR_NIBS)))};
      else if (col >= 8'(DATA_COL) && col < 8'(DATA_COL + DATA_NIBS))
        code_d = {1'b0, nibble_at(row_word_q, 6'(col - 8'(DATA_COL - INSTR_NIBS - REG_NIBS)))};
    end

    glyph_line_d = pixel_y[3:0];
    bit1_d       = pixel_x[2:0];
    bit2_d       = bit1_q;
    von_pipe_d   = {von_pipe_q[0], video_on_in};
    hs_pipe_d    = {hs_pipe_q[1:0], hsync_in};
    vs_pipe_d    = {vs_pipe_q[1:0], vsync_in};

    rgb_d = 12'h000;
    if (von_pipe_q[1]) rgb_d = font_bits[3'd7 - bit2_q] ? FG_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_address_q <= '0;
      row_word_q     <= '0;
      row_idx_q      <= '0;
      code_q         <= '0;
      glyph_line_q   <= '0;
      bit1_q         <= '0;
      bit2_q         <= '0;
      von_pipe_q     <= '0;
      hs_pipe_q      <= '0;
      vs_pipe_q      <= '0;
      rgb_q          <= '0;
    end else begin
      read_address_q <= read_address_d;
      row_word_q     <= row_word_d;
      row_idx_q      <= row_idx_d;
      code_q         <= code_d;
      glyph_line_q   <= glyph_line_d;
      bit1_q         <= bit1_d;
      bit2_q         <= bit2_d;
      von_pipe_q     <= von_pipe_d;
      hs_pipe_q      <= hs_pipe_d;
      vs_pipe_q      <= vs_pipe_d;
      rgb_q          <= rgb_d;
    end
  end

  hex_font_rom u_font (
    .clk        (clk),
    .rst        (rst),
    .glyph      (code_q),
    .glyph_line (glyph_line_q),
    .bitmap     (font_bits)
  );

  assign read_address = read_address_q;
  assign vga_rgb      = rgb_q;
  assign hsync        = hs_pipe_q[2];
  assign vsync        = vs_pipe_q[2];

endmodule
